// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty levels, occupancy count and sticky error flags.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter bit          FWFT       = 1'b0,
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0] PtrOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] AfLevel = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AeLevel = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                  full_w, empty_w, pop_ok, push_ok;

  assign wr_idx  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_idx  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full_w  = (wr_idx == rd_idx) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign pop_ok  = pop & ~empty_w;
  assign push_ok = push & (~full_w | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    // A fresh error in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q & ~clr_err) | (push & ~push_ok);
    underflow_d = (underflow_q & ~clr_err) | (pop & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_idx] <= wr_data;
  end

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count >= AfLevel);
  assign almost_empty = (count <= AeLevel);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  if (FWFT) begin : g_fwft
    assign rd_data  = mem_q[rd_idx];
    assign rd_valid = ~empty_w;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = pop_ok;
      if (pop_ok) rd_data_d = mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: three instances (depth 4 standard, depth 4 FWFT, depth 16
// standard) share one stimulus stream and are checked every cycle against a queue model.
module tb_param_sync_fifo;

  localparam int unsigned DP  [3] = '{4, 4, 16};
  localparam int unsigned AFL [3] = '{2, 2, 12};
  localparam int unsigned AEL [3] = '{2, 2, 2};
  localparam bit          FW  [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset, push, pop, clr_err;
  logic [31:0] wr_data;

  logic [31:0] rd_w [3];
  logic [2:0]  rv_w, full_w, empty_w, af_w, ae_w, ovf_w, unf_w;
  logic [2:0]  c0, c1;
  logic [4:0]  c2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .FWFT(1'b0)) u0 (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_w[0]), .rd_valid(rv_w[0]), .full(full_w[0]), .empty(empty_w[0]),
    .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(c0),
    .overflow(ovf_w[0]), .underflow(unf_w[0]), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .FWFT(1'b1)) u1 (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_w[1]), .rd_valid(rv_w[1]), .full(full_w[1]), .empty(empty_w[1]),
    .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(c1),
    .overflow(ovf_w[1]), .underflow(unf_w[1]), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2),
                    .FWFT(1'b0)) u2 (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_w[2]), .rd_valid(rv_w[2]), .full(full_w[2]), .empty(empty_w[2]),
    .almost_full(af_w[2]), .almost_empty(ae_w[2]), .count(c2),
    .overflow(ovf_w[2]), .underflow(unf_w[2]), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return {29'b0, c0};
      1:       return {29'b0, c1};
      default: return {27'b0, c2};
    endcase
  endfunction

  // Reference model: each FIFO is a plain queue; errors and read-port state tracked alongside.
  logic [31:0] mq [3][$];
  logic        m_ovf [3];
  logic        m_unf [3];
  logic        m_rv  [3];
  logic [31:0] m_rd  [3];
  bit          live = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int   n;
      logic pok, wok;
      if (reset) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        m_rv[i]  = 1'b0;
        m_rd[i]  = '0;
      end else begin
        n   = mq[i].size();
        pok = pop && (n > 0);
        wok = push && ((n < int'(DP[i])) || pok);
        m_rv[i] = 1'b0;
        if (pok) begin
          m_rd[i] = mq[i].pop_front();
          m_rv[i] = 1'b1;
        end
        if (wok) mq[i].push_back(wr_data);
        m_ovf[i] = (m_ovf[i] && !clr_err) || (push && !wok);
        m_unf[i] = (m_unf[i] && !clr_err) || (pop && !pok);
      end
    end
    if (reset) live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 3; i++) begin
        int n;
        n = mq[i].size();
        chk($sformatf("u%0d.count", i), cnt_of(i), n);
        chk($sformatf("u%0d.empty", i), empty_w[i], n == 0);
        chk($sformatf("u%0d.full", i), full_w[i], n == int'(DP[i]));
        chk($sformatf("u%0d.almost_full", i), af_w[i], n >= int'(AFL[i]));
        chk($sformatf("u%0d.almost_empty", i), ae_w[i], n <= int'(AEL[i]));
        chk($sformatf("u%0d.overflow", i), ovf_w[i], m_ovf[i]);
        chk($sformatf("u%0d.underflow", i), unf_w[i], m_unf[i]);
        if (FW[i]) begin
          chk($sformatf("u%0d.rd_valid", i), rv_w[i], n != 0);
          if (n != 0) chk($sformatf("u%0d.rd_data", i), rd_w[i], mq[i][0]);
        end else begin
          chk($sformatf("u%0d.rd_valid", i), rv_w[i], m_rv[i]);
          chk($sformatf("u%0d.rd_data", i), rd_w[i], m_rd[i]);
        end
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge that consumed them.
  task automatic cyc(input logic r, input logic p, input logic [31:0] d, input logic o,
                     input logic c);
    reset   = r;
    push    = p;
    wr_data = d;
    pop     = o;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst.count", cnt_of(0), 0);
    chk("rst.empty", empty_w[0], 1);
    chk("rst.full", full_w[0], 0);
    chk("rst.almost_empty", ae_w[0], 1);
    chk("rst.almost_full", af_w[0], 0);
    chk("rst.overflow", ovf_w[0], 0);
    chk("rst.rd_valid", rv_w[0], 0);
    chk("rst.rd_data", rd_w[0], 0);
    chk("rst.fwft_rd_valid", rv_w[1], 0);

    // Fill depth-4, then overflow
    for (int k = 0; k < 4; k++) cyc(0, 1, 32'hA + k, 0, 0);
    chk("fill.count", cnt_of(0), 4);
    chk("fill.full", full_w[0], 1);
    chk("fill.almost_full", af_w[0], 1);
    chk("fill.model_size", mq[0].size(), 4);
    chk("fill.fwft_valid", rv_w[1], 1);
    chk("fill.fwft_data", rd_w[1], 32'hA);
    cyc(0, 1, 32'hE, 0, 0);
    chk("ovf.flag", ovf_w[0], 1);
    chk("ovf.count", cnt_of(0), 4);
    chk("ovf.deep_count", cnt_of(2), 5);
    chk("ovf.deep_flag", ovf_w[2], 0);

    // Drain in order
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk("drain.rd_valid", rv_w[0], 1);
      chk("drain.rd_data", rd_w[0], 32'hA + k);
    end
    chk("drain.empty", empty_w[0], 1);
    cyc(0, 0, 0, 0, 0);
    chk("idle.rd_valid", rv_w[0], 0);
    chk("idle.rd_hold", rd_w[0], 32'hD);
    cyc(0, 0, 0, 0, 1);
    chk("clr.overflow", ovf_w[0], 0);

    // Underflow and clear priority
    cyc(0, 0, 0, 1, 0);
    chk("unf.flag", unf_w[0], 1);
    chk("unf.rd_valid", rv_w[0], 0);
    chk("unf.deep_data", rd_w[2], 32'hE);
    cyc(0, 0, 0, 0, 1);
    chk("unf.cleared", unf_w[0], 0);
    cyc(0, 0, 0, 1, 1);
    chk("unf.clr_loses", unf_w[0], 1);
    cyc(0, 0, 0, 0, 1);

    // Push+pop on full, pointer wrap
    for (int k = 1; k <= 4; k++) cyc(0, 1, k, 0, 0);
    cyc(0, 1, 32'h5, 1, 0);
    chk("pp.overflow", ovf_w[0], 0);
    chk("pp.count", cnt_of(0), 4);
    chk("pp.rd_data", rd_w[0], 1);
    for (int k = 2; k <= 5; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk("wrap.rd_data", rd_w[0], k);
    end
    chk("wrap.empty", empty_w[0], 1);

    // FWFT behaviour
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'h11, 0, 0);
    chk("fwft.valid", rv_w[1], 1);
    chk("fwft.data", rd_w[1], 32'h11);
    cyc(0, 1, 32'h22, 1, 0);
    chk("fwft.next", rd_w[1], 32'h22);
    chk("fwft.count", cnt_of(1), 1);
    cyc(0, 0, 0, 1, 0);
    chk("fwft.drained", rv_w[1], 0);

    // Threshold sweep on depth 16
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, k, 0, 0);
      chk("sweep.count", cnt_of(2), k);
      chk("sweep.ae", ae_w[2], k <= 2);
      chk("sweep.af", af_w[2], k >= 12);
    end
    chk("sweep.full", full_w[2], 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk("sweep.rd_data", rd_w[2], k);
      chk("sweep.ae_drain", ae_w[2], (16 - k) <= 2);
      chk("sweep.af_drain", af_w[2], (16 - k) >= 12);
    end

    // Random traffic with occasional mid-run resets, alternating fill/drain bias
    for (int k = 0; k < 10000; k++) begin
      bit fill;
      fill = ((k / 100) % 2) == 0;
      cyc($urandom_range(0, 499) == 0,
          fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          $urandom,
          fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 19) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
